// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_packet_fifo
//  Description : AXI-Stream FIFO for multi-word beats with a last flag.
//                Streaming (cut-through) or packet (store-and-forward) mode,
//                with beat and complete-packet occupancy reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_fifo #(
  parameter  int WORD_W         = 8,
  parameter  int BUS_W          = 8,
  parameter  int DEPTH          = 16,
  parameter  int PACKET_MODE    = 0,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int CNT_W          = $clog2(DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] m_data,
  output logic                                  m_last,
  output logic [CNT_W-1:0]                      count,
  output logic [CNT_W-1:0]                      pkt_count
);

  localparam int               c_IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  // Storage entry layout: {last, data}
  logic [BUS_W:0]     r_mem [DEPTH];
  logic [CNT_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic [BUS_W:0]     w_head;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]) &&
                   (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]);

  // Ready depends only on stored state and reset, never on m_ready, so a
  // full FIFO refuses a push even when a pop happens in the same cycle.
  assign s_ready = !w_full && !rst;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = m_valid && m_ready;

  // First-word-fall-through head entry
  assign w_head    = r_mem[r_rd_ptr[c_IDX_W-1:0]];
  assign m_last    = w_head[BUS_W];
  assign m_data    = w_head[BUS_W-1:0];
  assign count     = r_wr_ptr - r_rd_ptr;
  assign pkt_count = r_pkt_cnt;

  // Beat storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_IDX_W-1:0]] <= {s_last, s_data};
    end
  end

  // Read/write pointers, wrapping naturally at 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
    end
  end

  // Complete-packet counter: a last beat in and a last beat out cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_push && s_last, w_pop && m_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + c_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - c_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  generate
    if (PACKET_MODE != 0) begin : g_packet
      // Draining tracker: once a packet starts leaving, the rest of it
      // follows cut-through. This is what lets a packet longer than DEPTH
      // escape after the FIFO fills instead of deadlocking.
      localparam logic [0:0] c_ST_HOLD  = 1'b0;
      localparam logic [0:0] c_ST_DRAIN = 1'b1;

      logic [0:0] r_state;
      logic [0:0] w_state_nxt;
      logic       w_draining;

      // State register
      always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_HOLD;
        else     r_state <= w_state_nxt;
      end

      // Next state: enter on a non-last pop, leave on the last-beat pop
      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          c_ST_HOLD:  if (w_pop && !m_last) w_state_nxt = c_ST_DRAIN;
          c_ST_DRAIN: if (w_pop &&  m_last) w_state_nxt = c_ST_HOLD;
          default:    w_state_nxt = c_ST_HOLD;
        endcase
      end

      // Output decode: release a beat when a whole packet is stored, the
      // FIFO is full, or a packet is already partway out
      always_comb begin
        w_draining = (r_state == c_ST_DRAIN);
        m_valid    = !w_empty && (w_draining || (r_pkt_cnt != '0) || w_full);
      end
    end else begin : g_stream
      assign m_valid = !w_empty;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_packet_fifo
//  Description : Self-checking bench for axis_packet_fifo (streaming DEPTH=4,
//                packet DEPTH=8, packet DEPTH=4 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_fifo;

  localparam int WW  = 8;
  localparam int BW  = 32;
  localparam int WPB = BW / WW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance a: streaming, DEPTH 4
  logic                    a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_last;
  logic [WPB-1:0][WW-1:0]  a_s_data, a_m_data;
  logic [2:0]              a_count, a_pkt;
  // Instance b: packet, DEPTH 8
  logic                    b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_last;
  logic [WPB-1:0][WW-1:0]  b_s_data, b_m_data;
  logic [3:0]              b_count, b_pkt;
  // Instance c: packet, DEPTH 4
  logic                    c_s_valid, c_s_ready, c_s_last, c_m_valid, c_m_ready, c_m_last;
  logic [WPB-1:0][WW-1:0]  c_s_data, c_m_data;
  logic [2:0]              c_count, c_pkt;

  axis_packet_fifo #(.WORD_W(WW), .BUS_W(BW), .DEPTH(4), .PACKET_MODE(0)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_last(a_s_last), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .m_last(a_m_last), .count(a_count), .pkt_count(a_pkt));

  axis_packet_fifo #(.WORD_W(WW), .BUS_W(BW), .DEPTH(8), .PACKET_MODE(1)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .m_last(b_m_last), .count(b_count), .pkt_count(b_pkt));

  axis_packet_fifo #(.WORD_W(WW), .BUS_W(BW), .DEPTH(4), .PACKET_MODE(1)) u_c (
    .clk(clk), .rst(rst), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .s_last(c_s_last), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .m_last(c_m_last), .count(c_count), .pkt_count(c_pkt));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Random/directed traffic through instance c with a scoreboard queue
  task automatic run_traffic(input int n_pkts, input int beats, input int v_pct,
                             input int r_pct, input bit chk_full);
    logic [32:0] q[$];
    int  tx;
    int  rx;
    int  cyc;
    bit  seen;
    bit  acc;
    tx = 0; rx = 0; cyc = 0; seen = 1'b0;
    for (int p = 0; p < n_pkts; p++)
      for (int b = 0; b < beats; b++)
        q.push_back({(b == beats - 1), 32'($urandom())});
    while (rx < q.size() && cyc < 40000) begin
      if (!c_s_valid && tx < q.size() && $urandom_range(99) < v_pct) begin
        c_s_valid = 1'b1;
        {c_s_last, c_s_data} = q[tx];
      end
      c_m_ready = ($urandom_range(99) < r_pct);
      if (chk_full && !seen && c_m_valid) begin
        seen = 1'b1;
        check("first_valid_count", 64'(c_count), 64'd4);
      end
      if (c_m_valid && c_m_ready) begin
        check("rx_data", 64'(c_m_data), 64'(q[rx][31:0]));
        check("rx_last", 64'(c_m_last), 64'(q[rx][32]));
        rx++;
      end
      acc = c_s_valid && c_s_ready;
      step();
      cyc++;
      if (acc) begin
        tx++;
        c_s_valid = 1'b0;
      end
    end
    c_s_valid = 1'b0;
    c_m_ready = 1'b0;
    check("traffic_rx_beats", 64'(rx), 64'(q.size()));
    #1;
    check("traffic_pkt_end", 64'(c_pkt), 64'd0);
    check("traffic_empty", 64'(c_m_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {a_s_valid, a_s_last, a_m_ready, a_s_data} = '0;
    {b_s_valid, b_s_last, b_m_ready, b_s_data} = '0;
    {c_s_valid, c_s_last, c_m_ready, c_s_data} = '0;
    step(); step();

    // Reset state
    check("rst_a_m_valid", 64'(a_m_valid), 64'd0);
    check("rst_a_count",   64'(a_count),   64'd0);
    check("rst_a_s_ready", 64'(a_s_ready), 64'd0);
    check("rst_b_s_ready", 64'(b_s_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_a_s_ready", 64'(a_s_ready), 64'd1);
    check("post_rst_b_pkt",     64'(b_pkt),     64'd0);
    check("post_rst_c_m_valid", 64'(c_m_valid), 64'd0);

    // 1. Streaming free-flow
    step();
    a_m_ready = 1'b1;
    a_s_valid = 1'b1; a_s_data = 32'h03020100; a_s_last = 1'b0;
    step();
    check("t1_valid0", 64'(a_m_valid), 64'd1);
    check("t1_data0",  64'(a_m_data),  64'h03020100);
    check("t1_last0",  64'(a_m_last),  64'd0);
    check("t1_count0", 64'(a_count),   64'd1);
    a_s_data = 32'h07060504; a_s_last = 1'b1;
    step();
    a_s_valid = 1'b0;
    check("t1_data1",  64'(a_m_data),  64'h07060504);
    check("t1_last1",  64'(a_m_last),  64'd1);
    check("t1_count1", 64'(a_count),   64'd1);
    check("t1_pkt1",   64'(a_pkt),     64'd1);
    step();
    check("t1_empty",  64'(a_m_valid), 64'd0);
    check("t1_count2", 64'(a_count),   64'd0);
    check("t1_pkt2",   64'(a_pkt),     64'd0);

    // 2. Full / back-pressure
    a_m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_s_valid = 1'b1; a_s_data = 32'(32'h10 + i); a_s_last = 1'b0;
      step();
    end
    check("t2_full_count",   64'(a_count),   64'd4);
    check("t2_full_s_ready", 64'(a_s_ready), 64'd0);
    a_s_data = 32'h14; a_s_last = 1'b1;
    step();
    check("t2_hold_count",   64'(a_count),   64'd4);
    check("t2_hold_head",    64'(a_m_data),  64'h10);
    a_m_ready = 1'b1;
    step();
    a_m_ready = 1'b0;
    check("t2_pop_count",    64'(a_count),   64'd3);
    check("t2_pop_s_ready",  64'(a_s_ready), 64'd1);
    step();
    a_s_valid = 1'b0;
    check("t2_refill_count", 64'(a_count),   64'd4);
    check("t2_refill_pkt",   64'(a_pkt),     64'd1);
    a_m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_drain_data", 64'(a_m_data), 64'(32'h10 + i));
      check("t2_drain_last", 64'(a_m_last), 64'(i == 4));
      step();
    end
    a_m_ready = 1'b0;
    check("t2_end_valid", 64'(a_m_valid), 64'd0);
    check("t2_end_pkt",   64'(a_pkt),     64'd0);

    // 3. Packet-mode hold-off
    for (int i = 0; i < 3; i++) begin
      b_s_valid = 1'b1; b_s_data = 32'(32'h20 + i); b_s_last = 1'b0;
      step();
      check("t3_holdoff", 64'(b_m_valid), 64'd0);
    end
    b_s_data = 32'h23; b_s_last = 1'b1;
    step();
    b_s_valid = 1'b0;
    check("t3_release_valid", 64'(b_m_valid), 64'd1);
    check("t3_release_pkt",   64'(b_pkt),     64'd1);
    check("t3_release_count", 64'(b_count),   64'd4);
    b_m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_data", 64'(b_m_data), 64'(32'h20 + i));
      step();
    end
    b_m_ready = 1'b0;
    check("t3_end_pkt",   64'(b_pkt),     64'd0);
    check("t3_end_valid", 64'(b_m_valid), 64'd0);

    // 4. Oversize packet in DEPTH 4 packet FIFO
    run_traffic(1, 6, 100, 100, 1'b1);

    // 6. Reset mid-packet
    for (int i = 0; i < 3; i++) begin
      c_s_valid = 1'b1; c_s_data = 32'(32'h40 + i); c_s_last = 1'b0;
      step();
    end
    c_s_valid = 1'b0;
    check("t6_pre_count", 64'(c_count),   64'd3);
    check("t6_pre_valid", 64'(c_m_valid), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_count",   64'(c_count),   64'd0);
    check("t6_pkt",     64'(c_pkt),     64'd0);
    check("t6_m_valid", 64'(c_m_valid), 64'd0);
    check("t6_s_ready", 64'(c_s_ready), 64'd1);
    run_traffic(1, 3, 100, 100, 1'b0);

    // 5. Wrap and randomised traffic
    run_traffic(100, 10, 20, 10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
